// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph codes and active-low seven-segment patterns
package seg7_pkg;

  localparam logic [3:0] CODE_MINUS = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic       AN_OFF  = 1'b1;
  localparam logic       DP_OFF  = 1'b1;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_MINUS = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = SEG_OFF;

endpackage

// File: rtl/seg7_glyph_decode.sv
// rtl/seg7_glyph_decode.sv - 4-bit glyph code to active-low segment pattern
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = GLYPH_BLANK;
    case (code)
      4'h0: seg_n = GLYPH_0;
      4'h1: seg_n = GLYPH_1;
      4'h2: seg_n = GLYPH_2;
      4'h3: seg_n = GLYPH_3;
      4'h4: seg_n = GLYPH_4;
      4'h5: seg_n = GLYPH_5;
      4'h6: seg_n = GLYPH_6;
      4'h7: seg_n = GLYPH_7;
      4'h8: seg_n = GLYPH_8;
      4'h9: seg_n = GLYPH_9;
      4'hA: seg_n = GLYPH_A;
      4'hB: seg_n = GLYPH_B;
      4'hC: seg_n = GLYPH_C;
      4'hD: seg_n = GLYPH_D;
      CODE_MINUS: seg_n = GLYPH_MINUS;
      default: seg_n = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/multidigit_scan_driver.sv
// rtl/multidigit_scan_driver.sv - N-digit multiplexed 7-seg scanner with guard, PWM, LZS and double buffering
module multidigit_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DIV_W        = 5,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  neg_in,
  input  logic                  lzs_in,
  input  logic [DIV_W-1:0]      bright_in,
  input  logic                  load,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = '1;
  localparam logic [DIV_W-1:0] BLANK_W  = DIV_W'(BLANK_CYCLES);
  localparam logic [N_DIGITS-1:0] ONE_HOT_0 = N_DIGITS'(1);

  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;

  logic [4*N_DIGITS-1:0] disp_digits, pend_digits;
  logic [N_DIGITS-1:0]   disp_dp, pend_dp;
  logic                  disp_neg, pend_neg;
  logic                  disp_lzs, pend_lzs;
  logic [DIV_W-1:0]      disp_bright, pend_bright;
  logic                  pend_valid;

  logic                  slot_end, commit, lit, suppress;
  logic                  all_zero_left;
  logic [N_DIGITS-1:0]   lead_zero;
  logic [3:0]            cur_code, sel_code;
  logic [6:0]            glyph_n;
  logic [N_DIGITS-1:0]   an_next;

  assign slot_end = (div_cnt == DIV_MAX);
  assign commit   = slot_end && (idx == '0);

  // Guard first, then a bright-cycle window that naturally clips at slot end
  assign lit = (div_cnt >= BLANK_W) && ((div_cnt - BLANK_W) < disp_bright);

  // lead_zero[i]: digit i and every digit to its left are zero
  always_comb begin
    all_zero_left = 1'b1;
    lead_zero     = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      all_zero_left = all_zero_left && (disp_digits[4*i +: 4] == 4'h0);
      lead_zero[i]  = all_zero_left;
    end
  end

  assign cur_code = disp_digits[4*int'(idx) +: 4];
  assign suppress = disp_lzs && lead_zero[idx] && (idx != '0);

  always_comb begin
    sel_code = cur_code;
    if (idx == IDX_LAST && disp_neg) begin
      sel_code = CODE_MINUS;
    end else if (suppress) begin
      sel_code = CODE_BLANK;
    end
  end

  seg7_glyph_decode u_decode (
    .code  (sel_code),
    .seg_n (glyph_n)
  );

  assign an_next = ~(ONE_HOT_0 << idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= IDX_LAST;
      disp_digits <= {N_DIGITS{CODE_BLANK}};
      disp_dp     <= '0;
      disp_neg    <= 1'b0;
      disp_lzs    <= 1'b0;
      disp_bright <= '0;
      pend_digits <= {N_DIGITS{CODE_BLANK}};
      pend_dp     <= '0;
      pend_neg    <= 1'b0;
      pend_lzs    <= 1'b0;
      pend_bright <= '0;
      pend_valid  <= 1'b0;
      an_o        <= {N_DIGITS{AN_OFF}};
      seg_o       <= SEG_OFF;
      dp_o        <= DP_OFF;
      frame_o     <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == '0) ? IDX_LAST : idx - 1'b1;
      end

      // Whole-frame swap only at the frame boundary so digits never tear
      if (commit && pend_valid) begin
        disp_digits <= pend_digits;
        disp_dp     <= pend_dp;
        disp_neg    <= pend_neg;
        disp_lzs    <= pend_lzs;
        disp_bright <= pend_bright;
      end

      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
        pend_neg    <= neg_in;
        pend_lzs    <= lzs_in;
        pend_bright <= bright_in;
        pend_valid  <= 1'b1;
      end else if (commit) begin
        pend_valid  <= 1'b0;
      end

      frame_o <= commit;
      if (lit) begin
        an_o  <= an_next;
        seg_o <= glyph_n;
        dp_o  <= ~disp_dp[idx];
      end else begin
        an_o  <= {N_DIGITS{AN_OFF}};
        seg_o <= SEG_OFF;
        dp_o  <= DP_OFF;
      end
    end
  end

endmodule

// File: doc/multidigit_scan_driver.md
Name: multidigit_scan_driver

Overview:
Time-multiplexed scan driver for an N-digit common-anode seven-segment display. It is the parametrised successor of the calculator's 4-digit driver, with these additions:
- configurable digit count and dwell time
- anti-ghosting blank guard
- PWM brightness
- leading-zero suppression
- decimal points
- tear-free double-buffered loading

It sits between the calculator datapath (BCD result) and the board pins.

Parameters:
N_DIGITS, 4, number of digits scanned (≥2).
DIV_W, 5, slot counter width; each digit dwells 2^DIV_W clk cycles.
BLANK_CYCLES, 4, cycles at start of each slot with anode and segments off (< 2^DIV_W).

Ports:
clk  in  1  system clock; one clock domain.
rst  in  1  synchronous, active-high reset.
digits_in  in  4*N_DIGITS  digit codes; [3:0] is rightmost digit.
dp_in  in  N_DIGITS  decimal-point enables, bit i = digit i.
neg_in  in  1  show minus on leftmost digit.
lzs_in  in  1  leading-zero suppression enable.
bright_in  in  DIV_W  lit cycles per slot after guard.
load  in  1  capture digits_in/dp_in/neg_in/lzs_in/bright_in into pending buffer.
an_o  out  N_DIGITS  anodes, active-low.
seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low.
dp_o  out  1  decimal point, active-low.
frame_o  out  1  one-cycle pulse at each frame commit.

Behaviour:
- Clocking and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - an_o='1, seg_o='1, dp_o=1, frame_o=0.
  - div_cnt=0, idx=N_DIGITS-1.
  - Display buffer all codes 4'hF, dp=0, neg=0, lzs=0, bright=0.
  - Pending buffer = same values, pend_valid=0.
- Slot counter:
  - div_cnt increments every cycle and wraps 2^DIV_W-1→0.
  - On wrap, idx decrements; at 0 it wraps to N_DIGITS-1. Scan runs leftmost first.
- Frame commit:
  - Occurs on the cycle where div_cnt wraps and idx goes 0→N_DIGITS-1.
  - At commit: if pend_valid, display buffer ← pending and pend_valid←0. frame_o=1 whether or not pend_valid is set.
- Load:
  - load=1 in any cycle overwrites pending and sets pend_valid; the latest load wins.
  - load coincident with a commit goes to pending only; it is displayed next frame. A displayed frame never mixes old and new digits.
- Lit window:
  - lit = (div_cnt ≥ BLANK_CYCLES) && (div_cnt − BLANK_CYCLES < bright).
  - bright=0 → display dark. A bright value larger than the slot remainder saturates to the slot end.
- Glyph select for the digit at idx:
  - Leftmost digit with neg=1 → minus (code E).
  - Otherwise, if lzs=1 and this digit plus every digit to its left is 0 → blank. Digit 0 is never suppressed.
  - Otherwise the stored code.
  - neg takes priority over lzs on the leftmost digit.
- Decoder:
  - Codes 0–9 → numerals.
  - A, b, C, d → hex glyphs.
  - E → only g lit.
  - F → blank.
- Outputs are registered with 1-cycle latency from (div_cnt, idx):
  - When lit: an_o = ~onehot(idx), seg_o = decoded glyph, dp_o = ~dp[idx].
  - Otherwise all ones.
  - At most one anode is low at any time. The anode never changes while segments are lit.
- Reset mid-frame: outputs go blank the cycle after rst is sampled high. Pending and display buffers are discarded.

Decomposition:
- Package seg7_pkg holds:
  - Glyph code constants (CODE_MINUS=4'hE, CODE_BLANK=4'hF).
  - 7-bit glyph constants.
  - Active-low polarity constants.
- One combinational sub-module, seg7_glyph_decode (4-bit code → 7-bit active-low segments), which the display-board driver can reuse.

Test Plan:
- After rst, load digits=16'h1234, bright=28, N=4, DIV_W=5 → after first frame_o:
  - an_o sequence 0111, 1011, 1101, 1110.
  - seg_o = glyphs 1, 2, 3, 4, each lit for cycles 4..31 of its slot (1-cycle output lag).
  - All-ones during cycles 0..3.
- digits=16'h0070, lzs=1 → leftmost two digits blank, "7" then "0" shown; with lzs=0 → "0070".
- digits=16'h0042, neg=1, lzs=1 → minus on digit 3, digit 2 blank, "4", "2".
- Load 16'h1111 mid-frame, then load 16'h2222 before commit → current frame unchanged; next frame shows only 2222; frame_o pulses every 4·32 cycles.
- bright=0 → an_o and seg_o stay all ones for a full frame; bright=8 → exactly 8 lit cycles per slot.
- Assert rst for one cycle mid-slot → next cycle an_o='1; the following frame shows blank until a new load commits.
